// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state, mode encodings and parameter check for the serial arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic bit width_ok(input int width, input int digit);
    return digit > 0 && digit <= width && width % digit == 0;
  endfunction
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit add/subtract slice built from chained 1-bit cells
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  input  logic             mode,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);
  logic [DIGIT:0] w_c;
  assign w_c[0] = c_in;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic w_ai;
    // inverting a turns the majority carry into the subtractor borrow
    assign w_ai       = a_d[i] ^ mode;
    assign s_d[i]     = a_d[i] ^ b_d[i] ^ w_c[i];
    assign w_c[i+1]   = (w_ai & b_d[i]) | (w_ai & w_c[i]) | (b_d[i] & w_c[i]);
  end
  assign c_out    = w_c[DIGIT];
  assign c_msb_in = w_c[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: WIDTH-bit add/subtract processed DIGIT bits per clock with start/done handshake
module digit_serial_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_param
    $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_mode, r_c;
  logic [DIGIT-1:0] w_s;
  logic             w_c, w_cmsb, w_last;
  logic [WIDTH-1:0] w_acc_next;
  logic [DIGIT-1:0] w_unused_drop;
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d(r_a[DIGIT-1:0]), .b_d(r_b[DIGIT-1:0]), .c_in(r_c), .mode(r_mode),
    .s_d(w_s), .c_out(w_c), .c_msb_in(w_cmsb)
  );
  // result digits enter at the top, so the first digit ends up in the LSBs after N shifts
  assign {w_acc_next, w_unused_drop} = {w_s, r_acc};
  assign w_last = r_cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_mode  <= 1'b0;
      r_c     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_acc <= w_acc_next;
          r_c   <= w_c;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_acc_next;
            cout    <= w_c;
            ovf     <= w_cmsb ^ w_c;
          end
        end
        default: begin
          done    <= 1'b0;
          r_state <= start ? RUN : IDLE;
          busy    <= start;
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_c    <= cin;
            r_cnt  <= '0;
          end
        end
      endcase
    end
  end
endmodule
